// File: rtl/oam_dma_engine.sv
// oam_dma_engine: copies XFER_LEN bytes from page SRC into OAM through the MMU DMA port
module oam_dma_engine #(
  parameter int READ_LAT = 1,
  parameter int XFER_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_addr_select,
  input  logic [7:0]  mmio_write_value,
  input  logic        mmio_write_enable,
  output logic [7:0]  mmio_read_out,
  output logic [15:0] dma_addr_select,
  output logic [7:0]  dma_write_value,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_read_out,
  output logic        active
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam int CW = $clog2(READ_LAT + 2);
  logic [1:0]    state;
  logic [7:0]    src, src_l, idx, data;
  logic [CW-1:0] cnt;
  logic          we_q, sel, start, last_byte, cnt_done;
  assign sel       = mmio_addr_select == 16'hFF46;
  assign start     = sel & mmio_write_enable & ~we_q;
  assign last_byte = idx == 8'(XFER_LEN - 1);
  assign cnt_done  = cnt == CW'(READ_LAT);
  // SRC register and write-enable history used for start edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      src  <= 8'hFF;
      we_q <= 1'b0;
    end else begin
      we_q <= mmio_write_enable;
      if (sel && mmio_write_enable) src <= mmio_write_value;
    end
  end
  // transfer sequencer; a start in any state restarts from byte 0 of the new page
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src_l <= 8'hFF;
      idx   <= 8'h00;
      cnt   <= '0;
      data  <= 8'h00;
    end else if (start) begin
      state <= READ;
      src_l <= mmio_write_value;
      idx   <= 8'h00;
      cnt   <= '0;
    end else begin
      case (state)
        READ: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) begin
            data  <= dma_read_out;
            state <= WRITE;
          end
        end
        WRITE: begin
          cnt   <= '0;
          state <= last_byte ? IDLE : READ;
          if (!last_byte) idx <= idx + 8'h01;
        end
        IDLE:    cnt <= '0;
        default: state <= IDLE;
      endcase
    end
  end
  // bus and register outputs decoded from the registered state
  always_comb begin
    dma_addr_select  = state == READ ? {src_l, idx} : state == WRITE ? {8'hFE, idx} : 16'hFFFF;
    dma_write_enable = state == WRITE;
    dma_write_value  = state == WRITE ? data : 8'h00;
    active           = state != IDLE;
    mmio_read_out    = sel ? src : 8'hFF;
  end
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: randomized scenario bench for oam_dma_engine at READ_LAT 1 and 2
module tb_oam_dma_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] maddr = 16'h0000;
  logic [7:0]  mwv = 8'h00;
  logic        mwe = 1'b0;
  logic [7:0]  rd1, rd2, wv1, wv2, ro1, ro2;
  logic [15:0] a1, a2;
  logic        we1, we2, act1, act2;
  oam_dma_engine #(.READ_LAT(1), .XFER_LEN(160)) dut1 (
    .clk(clk), .rst(rst),
    .mmio_addr_select(maddr), .mmio_write_value(mwv), .mmio_write_enable(mwe), .mmio_read_out(rd1),
    .dma_addr_select(a1), .dma_write_value(wv1), .dma_write_enable(we1), .dma_read_out(ro1),
    .active(act1));
  oam_dma_engine #(.READ_LAT(2), .XFER_LEN(160)) dut2 (
    .clk(clk), .rst(rst),
    .mmio_addr_select(maddr), .mmio_write_value(mwv), .mmio_write_enable(mwe), .mmio_read_out(rd2),
    .dma_addr_select(a2), .dma_write_value(wv2), .dma_write_enable(we2), .dma_read_out(ro2),
    .active(act2));
  logic [7:0]  mem1 [65536];
  logic [7:0]  mem2 [65536];
  logic [15:0] p1, p2a, p2b;
  assign ro1 = mem1[p1];
  assign ro2 = mem2[p2b];
  always @(posedge clk) begin
    p1  <= a1;
    p2a <= a2;
    p2b <= p2a;
    if (we1) mem1[a1] <= wv1;
    if (we2) mem2[a2] <= wv2;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int asserts = 0, fails = 0;
  bit mon_on = 0;
  int c1[$], c2[$], ec[$];
  logic [15:0] ad1[$], ad2[$], ea[$];
  logic [7:0]  d1[$], d2[$], ed[$];
  int af1 = -1, al1 = -1, af2 = -1, al2 = -1;
  always @(negedge clk) begin
    if (we1) begin c1.push_back(cyc); ad1.push_back(a1); d1.push_back(wv1); end
    if (we2) begin c2.push_back(cyc); ad2.push_back(a2); d2.push_back(wv2); end
    if (act1) begin if (af1 < 0) af1 = cyc; al1 = cyc; end
    if (act2) begin if (af2 < 0) af2 = cyc; al2 = cyc; end
    if (mon_on) begin
      asserts++;
      if (act1 !== 1'b1 && (a1 !== 16'hFFFF || we1 !== 1'b0 || wv1 !== 8'h00)) begin
        fails++;
        $display("FAIL idle_bus1 cyc %0d: addr=%h we=%b data=%h, need FFFF/0/00", cyc, a1, we1, wv1);
      end
      asserts++;
      if (act2 !== 1'b1 && (a2 !== 16'hFFFF || we2 !== 1'b0 || wv2 !== 8'h00)) begin
        fails++;
        $display("FAIL idle_bus2 cyc %0d: addr=%h we=%b data=%h, need FFFF/0/00", cyc, a2, we2, wv2);
      end
    end
  end
  function automatic void model(input logic [7:0] src, input int t, input int lat, input int n);
    for (int i = 0; i < n; i++) begin
      ec.push_back(t + (lat + 2) * (i + 1));
      ea.push_back(16'hFE00 + 16'(i));
      ed.push_back(mem1[{src, 8'(i)}]);
    end
  endfunction
  task automatic clear();
    c1.delete(); ad1.delete(); d1.delete();
    c2.delete(); ad2.delete(); d2.delete();
    ec.delete(); ea.delete(); ed.delete();
    af1 = -1; al1 = -1; af2 = -1; al2 = -1;
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask
  task automatic write_reg(input logic [7:0] v, input int hold, output int t);
    @(posedge clk); #1;
    maddr = 16'hFF46; mwv = v; mwe = 1'b1; t = cyc;
    repeat (hold) begin @(posedge clk); #1; end
    mwe = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((act1 || act2) && n < budget) begin @(posedge clk); #1; n++; end
    asserts++;
    if (act1 || act2) begin
      fails++;
      $display("FAIL idle_timeout: active1=%b active2=%b after %0d cycles, need 0/0", act1, act2, n);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; maddr = 16'hFF46;
    @(negedge clk);
    asserts++;
    if (a1 !== 16'hFFFF || we1 !== 1'b0 || act1 !== 1'b0 || a2 !== 16'hFFFF || act2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h/%h we=%b active=%b/%b, need FFFF 0 0", a1, a2, we1, act1, act2);
    end
    asserts++;
    if (rd1 !== 8'hFF || rd2 !== 8'hFF) begin
      fails++;
      $display("FAIL reset_src: got %h/%h, need FF", rd1, rd2);
    end
    maddr = 16'h0010;
    #1;
    asserts++;
    if (rd1 !== 8'hFF) begin
      fails++;
      $display("FAIL other_addr_read: got %h, need FF", rd1);
    end
    mon_on = 1;
  endtask
  task automatic test_basic();
    int t;
    for (int i = 0; i < 160; i++) begin
      mem1[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem2[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
    end
    clear();
    @(posedge clk); #1;
    maddr = 16'hFF46; mwv = 8'hC0; mwe = 1'b1; t = cyc;
    @(negedge clk);
    asserts++;
    if (rd1 !== 8'hFF) begin
      fails++;
      $display("FAIL src_early: got %h in write cycle, need FF", rd1);
    end
    @(posedge clk); #1 mwe = 1'b0;
    @(negedge clk);
    asserts++;
    if (rd1 !== 8'hC0) begin
      fails++;
      $display("FAIL src_visible: got %h, need C0", rd1);
    end
    model(8'hC0, t, 1, 160);
    wait_idle(1200);
    asserts++;
    if (c1.size() !== ec.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d writes, need %0d", c1.size(), ec.size());
    end
    for (int i = 0; i < c1.size() && i < ec.size(); i++) begin
      asserts++;
      if (c1[i] !== ec[i] || ad1[i] !== ea[i] || d1[i] !== ed[i]) begin
        fails++;
        $display("FAIL basic_write %0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", i, c1[i] - t, ad1[i], d1[i], ec[i] - t, ea[i], ed[i]);
      end
    end
    asserts++;
    if (af1 !== t + 1 || al1 !== t + 480) begin
      fails++;
      $display("FAIL basic_active: T+%0d..T+%0d, need T+1..T+480", af1 - t, al1 - t);
    end
    for (int i = 0; i < 160; i++) begin
      asserts++;
      if (mem1[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
        fails++;
        $display("FAIL basic_oam %0d: got %h, need %h", i, mem1[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
      end
    end
  endtask
  task automatic test_random();
    int t;
    logic [7:0] src;
    for (int k = 0; k < 3; k++) begin
      src = 8'($urandom_range(0, 253));
      clear();
      write_reg(src, 1, t);
      model(src, t, 1, 160);
      wait_idle(1200);
      asserts++;
      if (c1.size() !== ec.size()) begin
        fails++;
        $display("FAIL rand_count src %h: got %0d, need %0d", src, c1.size(), ec.size());
      end
      for (int i = 0; i < c1.size() && i < ec.size(); i++) begin
        asserts++;
        if (c1[i] !== ec[i] || ad1[i] !== ea[i] || d1[i] !== ed[i]) begin
          fails++;
          $display("FAIL rand_write src %h #%0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", src, i, c1[i] - t, ad1[i], d1[i], ec[i] - t, ea[i], ed[i]);
        end
      end
    end
  endtask
  task automatic test_held();
    int t;
    clear();
    write_reg(8'h80, 4, t);
    model(8'h80, t, 1, 160);
    #1;
    asserts++;
    if (rd1 !== 8'h80) begin
      fails++;
      $display("FAIL held_readback: got %h, need 80", rd1);
    end
    wait_idle(1200);
    asserts++;
    if (c1.size() !== 160 || af1 !== t + 1 || al1 !== t + 480) begin
      fails++;
      $display("FAIL held_single: %0d writes active T+%0d..T+%0d, need 160 T+1..T+480", c1.size(), af1 - t, al1 - t);
    end
    for (int i = 0; i < c1.size() && i < ec.size(); i++) begin
      asserts++;
      if (c1[i] !== ec[i] || ad1[i] !== ea[i] || d1[i] !== ed[i]) begin
        fails++;
        $display("FAIL held_write %0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", i, c1[i] - t, ad1[i], d1[i], ec[i] - t, ea[i], ed[i]);
      end
    end
  endtask
  task automatic test_restart();
    int t1, t2;
    clear();
    write_reg(8'hC0, 1, t1);
    wait_cyc(t1 + 149);
    write_reg(8'hC1, 1, t2);
    @(negedge clk);
    asserts++;
    if (t2 !== t1 + 150 || a1 !== 16'hC100 || we1 !== 1'b0) begin
      fails++;
      $display("FAIL restart_read: T2-T1=%0d addr %h we %b, need 150 C100 0", t2 - t1, a1, we1);
    end
    model(8'hC0, t1, 1, 50);
    model(8'hC1, t2, 1, 160);
    wait_idle(1200);
    asserts++;
    if (c1.size() !== ec.size() || af1 !== t1 + 1 || al1 - af1 + 1 !== 630) begin
      fails++;
      $display("FAIL restart_span: %0d writes active len %0d, need %0d and 630", c1.size(), al1 - af1 + 1, ec.size());
    end
    for (int i = 0; i < c1.size() && i < ec.size(); i++) begin
      asserts++;
      if (c1[i] !== ec[i] || ad1[i] !== ea[i] || d1[i] !== ed[i]) begin
        fails++;
        $display("FAIL restart_write %0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", i, c1[i] - t1, ad1[i], d1[i], ec[i] - t1, ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 160; i++) begin
      asserts++;
      if (mem1[16'hFE00 + 16'(i)] !== mem1[16'hC100 + 16'(i)]) begin
        fails++;
        $display("FAIL restart_oam %0d: got %h, need %h", i, mem1[16'hFE00 + 16'(i)], mem1[16'hC100 + 16'(i)]);
      end
    end
  endtask
  task automatic test_reset_mid();
    int t;
    clear();
    write_reg(8'hC0, 1, t);
    model(8'hC0, t, 1, 21);
    wait_cyc(t + 63);
    rst = 1'b1;
    @(negedge clk);
    asserts++;
    if (we1 !== 1'b1 || a1 !== 16'hFE14) begin
      fails++;
      $display("FAIL rstmid_write: addr %h we %b, need FE14 1", a1, we1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    asserts++;
    if (a1 !== 16'hFFFF || act1 !== 1'b0 || we1 !== 1'b0 || rd1 !== 8'hFF || act2 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: addr %h active %b/%b we %b src %h, need FFFF 0/0 0 FF", a1, act1, act2, we1, rd1);
    end
    repeat (20) @(posedge clk);
    #1;
    asserts++;
    if (c1.size() !== 21) begin
      fails++;
      $display("FAIL rstmid_count: got %0d writes, need 21", c1.size());
    end
    for (int i = 0; i < c1.size() && i < ec.size(); i++) begin
      asserts++;
      if (c1[i] !== ec[i] || ad1[i] !== ea[i] || d1[i] !== ed[i]) begin
        fails++;
        $display("FAIL rstmid_write %0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", i, c1[i] - t, ad1[i], d1[i], ec[i] - t, ea[i], ed[i]);
      end
    end
  endtask
  task automatic test_rom_lat2();
    int t;
    clear();
    write_reg(8'h12, 1, t);
    model(8'h12, t, 2, 160);
    wait_idle(1500);
    asserts++;
    if (c2.size() !== 160 || af2 !== t + 1 || al2 !== t + 640) begin
      fails++;
      $display("FAIL rom_span: %0d writes active T+%0d..T+%0d, need 160 T+1..T+640", c2.size(), af2 - t, al2 - t);
    end
    for (int i = 0; i < c2.size() && i < ec.size(); i++) begin
      asserts++;
      if (c2[i] !== ec[i] || ad2[i] !== ea[i] || d2[i] !== ed[i]) begin
        fails++;
        $display("FAIL rom_write %0d: cyc %0d addr %h data %h, need cyc %0d addr %h data %h", i, c2[i] - t, ad2[i], d2[i], ec[i] - t, ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 160; i++) begin
      asserts++;
      if (mem2[16'hFE00 + 16'(i)] !== mem1[16'h1200 + 16'(i)]) begin
        fails++;
        $display("FAIL rom_oam %0d: got %h, need %h", i, mem2[16'hFE00 + 16'(i)], mem1[16'h1200 + 16'(i)]);
      end
    end
  endtask
  initial begin
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem1[i] = v;
      mem2[i] = v;
    end
    test_reset();
    test_basic();
    test_random();
    test_held();
    test_restart();
    test_reset_mid();
    test_rom_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
